axi_stream_pkt_fifo: RTL and testbench

AXI_STREAM_PKT_FIFO -- requirements
Module: axi_stream_pkt_fifo

---
 rtl/axi_stream_pkt_fifo.sv | 192 +++++++++++++++++++
 tb/tb_axi_stream_pkt_fifo.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_stream_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : axi_stream_pkt_fifo
// Description : Streaming word FIFO with sop/eop/err/mod/ctl sideband.
//               PKT_MODE=0 forwards words as soon as they are written
//               (cut-through). PKT_MODE=1 exposes a packet only once its eop
//               is committed (store-and-forward). Errored or oversize packets
//               are rewound and counted.
// Revision    : 1.0 - initial release
// ============================================================================
module axi_stream_pkt_fifo #(
    parameter int DAT_BYTS = 64,
    parameter int CTL_BITS = 8,
    parameter int DEPTH    = 16,
    parameter int PKT_MODE = 0,
    parameter int DROP_ERR = 1,
    localparam int MOD_BITS = (DAT_BYTS == 1) ? 1 : $clog2(DAT_BYTS),
    localparam int LVL_BITS = $clog2(DEPTH) + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_val,
    input  logic                  i_sop,
    input  logic                  i_eop,
    input  logic                  i_err,
    input  logic [MOD_BITS-1:0]   i_mod,
    input  logic [CTL_BITS-1:0]   i_ctl,
    input  logic [DAT_BYTS*8-1:0] i_dat,
    output logic                  i_rdy,
    output logic                  o_val,
    output logic                  o_sop,
    output logic                  o_eop,
    output logic                  o_err,
    output logic [MOD_BITS-1:0]   o_mod,
    output logic [CTL_BITS-1:0]   o_ctl,
    output logic [DAT_BYTS*8-1:0] o_dat,
    input  logic                  o_rdy,
    output logic [LVL_BITS-1:0]   o_level,
    output logic [15:0]           o_drop_cnt
);

    localparam int AW     = $clog2(DEPTH);
    localparam int PTR_W  = AW + 1;
    localparam int WORD_W = DAT_BYTS * 8 + CTL_BITS + MOD_BITS + 3;

    localparam logic [PTR_W-1:0] C_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0] C_DEPTH = PTR_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PKT     = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t             r_st;
    logic [PTR_W-1:0]   r_wp;
    logic [PTR_W-1:0]   r_cp;
    logic [PTR_W-1:0]   r_rp;
    logic               r_rdy_en;
    logic [WORD_W-1:0]  r_mem [DEPTH];

    logic               w_in_acc;
    logic               w_wr_en;
    logic               w_load;
    logic [PTR_W-1:0]   w_level;
    logic [PTR_W-1:0]   w_wp_inc;
    logic [PTR_W-1:0]   w_rp_nxt;
    logic               w_fill;
    logic               w_err_drop;
    logic [WORD_W-1:0]  w_in_word;
    logic [WORD_W-1:0]  w_rd_word;

    // Words held in storage; the egress register is not counted.
    assign w_level = r_wp - r_rp;
    assign o_level = w_level;

    // Held low through reset and re-enabled by the first edge afterwards.
    // DISCARD keeps accepting so the tail of a dropped packet can drain.
    assign i_rdy    = r_rdy_en && ((w_level < C_DEPTH) || (r_st == ST_DISCARD));
    assign w_in_acc = i_val && i_rdy;

    // Writing at wp is harmless unless wp aliases unread committed data,
    // which can only happen while discarding into full storage.
    assign w_wr_en = w_in_acc && ((PKT_MODE == 0) || (r_st != ST_DISCARD));

    // Egress register refills when it is empty or being emptied this cycle.
    assign w_load   = (r_rp != r_cp) && (!o_val || o_rdy);
    assign w_rp_nxt = r_rp + (w_load ? C_ONE : '0);
    assign w_wp_inc = r_wp + C_ONE;

    // The word being written would leave storage full before eop arrives.
    assign w_fill     = ((w_wp_inc - w_rp_nxt) == C_DEPTH);
    assign w_err_drop = i_eop && i_err && (DROP_ERR != 0);

    assign w_in_word = {i_err, i_eop, i_sop, i_mod, i_ctl, i_dat};
    assign w_rd_word = r_mem[r_rp[AW-1:0]];

    // Word storage; contents need no reset because pointers gate visibility.
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[r_wp[AW-1:0]] <= w_in_word;
        end
    end

    // Ingress FSM: write/commit pointers, packet state and drop counter.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_st       <= ST_IDLE;
            r_wp       <= '0;
            r_cp       <= '0;
            r_rdy_en   <= 1'b0;
            o_drop_cnt <= 16'd0;
        end else begin
            r_rdy_en <= 1'b1;
            if (PKT_MODE == 0) begin
                r_st <= ST_IDLE;
                if (w_in_acc) begin
                    r_wp <= w_wp_inc;
                    r_cp <= w_wp_inc;
                end
            end else if (w_in_acc) begin
                case (r_st)
                    ST_IDLE: begin
                        // Words without sop outside a packet are dropped silently.
                        if (i_sop) begin
                            if (i_eop) begin
                                if (w_err_drop) begin
                                    if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                                end else begin
                                    r_wp <= w_wp_inc;
                                    r_cp <= w_wp_inc;
                                end
                            end else if (w_fill) begin
                                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                                r_st <= ST_DISCARD;
                            end else begin
                                r_wp <= w_wp_inc;
                                r_st <= ST_PKT;
                            end
                        end
                    end
                    ST_PKT: begin
                        if (i_eop) begin
                            if (w_err_drop) begin
                                r_wp <= r_cp;
                                if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                            end else begin
                                r_wp <= w_wp_inc;
                                r_cp <= w_wp_inc;
                            end
                            r_st <= ST_IDLE;
                        end else if (w_fill) begin
                            r_wp <= r_cp;
                            if (o_drop_cnt != 16'hFFFF) o_drop_cnt <= o_drop_cnt + 16'd1;
                            r_st <= ST_DISCARD;
                        end else begin
                            r_wp <= w_wp_inc;
                        end
                    end
                    ST_DISCARD: begin
                        if (i_eop) r_st <= ST_IDLE;
                    end
                    default: r_st <= ST_IDLE;
                endcase
            end
        end
    end

    // Egress: read pointer and one-entry output register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rp  <= '0;
            o_val <= 1'b0;
            o_sop <= 1'b0;
            o_eop <= 1'b0;
            o_err <= 1'b0;
            o_mod <= '0;
            o_ctl <= '0;
            o_dat <= '0;
        end else begin
            r_rp <= w_rp_nxt;
            if (w_load) begin
                o_val <= 1'b1;
                {o_err, o_eop, o_sop, o_mod, o_ctl, o_dat} <= w_rd_word;
            end else if (o_rdy) begin
                o_val <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_stream_pkt_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_axi_stream_pkt_fifo
// Description : Directed vector bench for axi_stream_pkt_fifo. Instance 0 is
//               cut-through (64-byte words, DEPTH 4); instance 1 is
//               store-and-forward with error drop (4-byte words, DEPTH 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_stream_pkt_fifo;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0 signals
    logic         rst0 = 1'b1;
    logic         val0 = 0, sop0 = 0, eop0 = 0, err0 = 0, ordy0 = 0;
    logic [5:0]   mod0 = '0;
    logic [7:0]   ctl0 = '0;
    logic [511:0] dat0 = '0;
    logic         irdy0, oval0, osop0, oeop0, oerr0;
    logic [5:0]   omod0;
    logic [7:0]   octl0;
    logic [511:0] odat0;
    logic [2:0]   lvl0;
    logic [15:0]  drop0;

    // Instance 1 signals
    logic         rst1 = 1'b1;
    logic         val1 = 0, sop1 = 0, eop1 = 0, err1 = 0, ordy1 = 0;
    logic [1:0]   mod1 = '0;
    logic [7:0]   ctl1 = '0;
    logic [31:0]  dat1 = '0;
    logic         irdy1, oval1, osop1, oeop1, oerr1;
    logic [1:0]   omod1;
    logic [7:0]   octl1;
    logic [31:0]  odat1;
    logic [2:0]   lvl1;
    logic [15:0]  drop1;

    axi_stream_pkt_fifo #(
        .DAT_BYTS(64), .CTL_BITS(8), .DEPTH(4), .PKT_MODE(0), .DROP_ERR(1)
    ) u_m0 (
        .i_clk(clk), .i_rst(rst0),
        .i_val(val0), .i_sop(sop0), .i_eop(eop0), .i_err(err0),
        .i_mod(mod0), .i_ctl(ctl0), .i_dat(dat0), .i_rdy(irdy0),
        .o_val(oval0), .o_sop(osop0), .o_eop(oeop0), .o_err(oerr0),
        .o_mod(omod0), .o_ctl(octl0), .o_dat(odat0), .o_rdy(ordy0),
        .o_level(lvl0), .o_drop_cnt(drop0)
    );

    axi_stream_pkt_fifo #(
        .DAT_BYTS(4), .CTL_BITS(8), .DEPTH(4), .PKT_MODE(1), .DROP_ERR(1)
    ) u_m1 (
        .i_clk(clk), .i_rst(rst1),
        .i_val(val1), .i_sop(sop1), .i_eop(eop1), .i_err(err1),
        .i_mod(mod1), .i_ctl(ctl1), .i_dat(dat1), .i_rdy(irdy1),
        .o_val(oval1), .o_sop(osop1), .o_eop(oeop1), .o_err(oerr1),
        .o_mod(omod1), .o_ctl(octl1), .o_dat(odat1), .o_rdy(ordy1),
        .o_level(lvl1), .o_drop_cnt(drop1)
    );

    int checks = 0;
    int errors = 0;

    // One cycle of stimulus plus the outputs expected before that cycle's edge.
    // fi = {val,sop,eop,err}; fx = {i_rdy,o_val,o_sop,o_eop,o_err}.
    typedef struct packed {
        logic        inst;
        logic [3:0]  fi;
        logic [5:0]  mi;
        logic [7:0]  ti;
        logic        ordy;
        logic [4:0]  fx;
        logic [5:0]  mx;
        logic [7:0]  tx;
        logic [3:0]  lx;
        logic [15:0] dx;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic inst, input logic [3:0] fi, input logic [5:0] mi,
                                input logic [7:0] ti, input logic ordy, input logic [4:0] fx,
                                input logic [5:0] mx, input logic [7:0] tx, input int lx,
                                input int dx);
        vec_t v;
        v.inst = inst; v.fi = fi; v.mi = mi; v.ti = ti; v.ordy = ordy;
        v.fx = fx; v.mx = mx; v.tx = tx; v.lx = 4'(lx); v.dx = 16'(dx);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        logic         a_rdy, a_val, a_sop, a_eop, a_err;
        logic [5:0]   a_mod;
        logic [7:0]   a_ctl;
        logic [511:0] a_dat, x_dat;
        int           a_lvl, a_drop;
        int           stale;

        // ---- Cut-through: 3-word packet, mod 5, err carried on eop ----
        tbl.push_back(mk(0, 4'b1100, 0, 8'hA0, 1, 5'b10000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hA1, 1, 5'b10000, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 4'b1011, 5, 8'hA2, 1, 5'b11100, 0, 8'hA0, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hA1, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11011, 5, 8'hA2, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 0, 0));
        // ---- Cut-through: fill with egress stalled, then stream across wrap ----
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB0, 0, 5'b10000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB1, 0, 5'b10000, 0, 8'h00, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB2, 0, 5'b11000, 0, 8'hB0, 1, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB3, 0, 5'b11000, 0, 8'hB0, 2, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB4, 0, 5'b11000, 0, 8'hB0, 3, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB5, 0, 5'b01000, 0, 8'hB0, 4, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB5, 1, 5'b01000, 0, 8'hB0, 4, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB5, 1, 5'b11000, 0, 8'hB1, 3, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB6, 1, 5'b11000, 0, 8'hB2, 3, 0));
        tbl.push_back(mk(0, 4'b1000, 0, 8'hB7, 1, 5'b11000, 0, 8'hB3, 3, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hB4, 3, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hB5, 2, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hB6, 1, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hB7, 0, 0));
        tbl.push_back(mk(0, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 0, 0));
        // ---- Store-and-forward: 4-word packet held until eop commits ----
        tbl.push_back(mk(1, 4'b1100, 0, 8'hC0, 1, 5'b10000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hC1, 1, 5'b10000, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hC2, 1, 5'b10000, 0, 8'h00, 2, 0));
        tbl.push_back(mk(1, 4'b1010, 2, 8'hC3, 1, 5'b10000, 0, 8'h00, 3, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b00000, 0, 8'h00, 4, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11100, 0, 8'hC0, 3, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hC1, 2, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11000, 0, 8'hC2, 1, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11010, 2, 8'hC3, 0, 0));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 0, 0));
        // ---- Errored 2-word packet dropped, clean single word passes ----
        tbl.push_back(mk(1, 4'b1100, 0, 8'hD0, 1, 5'b10000, 0, 8'h00, 0, 0));
        tbl.push_back(mk(1, 4'b1011, 1, 8'hD1, 1, 5'b10000, 0, 8'h00, 1, 0));
        tbl.push_back(mk(1, 4'b1110, 3, 8'hD2, 1, 5'b10000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11110, 3, 8'hD2, 0, 1));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 0, 1));
        // ---- 6-word packet overflows DEPTH 4: dropped at fill, tail discarded ----
        tbl.push_back(mk(1, 4'b1100, 0, 8'hE0, 0, 5'b10000, 0, 8'h00, 0, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hE1, 0, 5'b10000, 0, 8'h00, 1, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hE2, 0, 5'b10000, 0, 8'h00, 2, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hE3, 0, 5'b10000, 0, 8'h00, 3, 1));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hE4, 0, 5'b10000, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 4'b1010, 0, 8'hE5, 0, 5'b10000, 0, 8'h00, 0, 2));
        // ---- Recovery after discard, then a stray non-sop word is ignored ----
        tbl.push_back(mk(1, 4'b1110, 1, 8'hF0, 1, 5'b10000, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 1, 2));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b11110, 1, 8'hF0, 0, 2));
        tbl.push_back(mk(1, 4'b1000, 0, 8'hF1, 1, 5'b10000, 0, 8'h00, 0, 2));
        tbl.push_back(mk(1, 4'b0000, 0, 8'h00, 1, 5'b10000, 0, 8'h00, 0, 2));

        // ---- Reset state ----
        repeat (2) @(negedge clk);
        #1;
        chk("rst.irdy0", 512'(irdy0), 512'(0));
        chk("rst.oval0", 512'(oval0), 512'(0));
        chk("rst.lvl0",  512'(lvl0),  512'(0));
        chk("rst.odat0", odat0,       512'(0));
        chk("rst.irdy1", 512'(irdy1), 512'(0));
        chk("rst.oval1", 512'(oval1), 512'(0));
        chk("rst.drop1", 512'(drop1), 512'(0));
        @(negedge clk);
        rst0 = 1'b0;
        rst1 = 1'b0;
        @(negedge clk);
        #1;
        chk("rel.irdy0", 512'(irdy0), 512'(1));
        chk("rel.irdy1", 512'(irdy1), 512'(1));

        // ---- Table sweep ----
        foreach (tbl[i]) begin
            @(negedge clk);
            if (tbl[i].inst == 1'b0) begin
                {val0, sop0, eop0, err0} = tbl[i].fi;
                mod0 = tbl[i].mi; ctl0 = tbl[i].ti; dat0 = {64{tbl[i].ti}};
                ordy0 = tbl[i].ordy; val1 = 1'b0;
            end else begin
                {val1, sop1, eop1, err1} = tbl[i].fi;
                mod1 = tbl[i].mi[1:0]; ctl1 = tbl[i].ti; dat1 = {4{tbl[i].ti}};
                ordy1 = tbl[i].ordy; val0 = 1'b0;
            end
            #1;
            if (tbl[i].inst == 1'b0) begin
                {a_rdy, a_val, a_sop, a_eop, a_err} = {irdy0, oval0, osop0, oeop0, oerr0};
                a_mod = omod0; a_ctl = octl0; a_dat = odat0; x_dat = {64{tbl[i].tx}};
                a_lvl = int'(lvl0); a_drop = int'(drop0);
            end else begin
                {a_rdy, a_val, a_sop, a_eop, a_err} = {irdy1, oval1, osop1, oeop1, oerr1};
                a_mod = {4'b0, omod1}; a_ctl = octl1; a_dat = {480'b0, odat1};
                x_dat = {480'b0, {4{tbl[i].tx}}};
                a_lvl = int'(lvl1); a_drop = int'(drop1);
            end
            chk($sformatf("v%0d.i_rdy", i), 512'(a_rdy), 512'(tbl[i].fx[4]));
            chk($sformatf("v%0d.o_val", i), 512'(a_val), 512'(tbl[i].fx[3]));
            chk($sformatf("v%0d.level", i), 512'(a_lvl), 512'(tbl[i].lx));
            chk($sformatf("v%0d.drop", i),  512'(a_drop), 512'(tbl[i].dx));
            if (tbl[i].fx[3]) begin
                chk($sformatf("v%0d.sop", i), 512'(a_sop), 512'(tbl[i].fx[2]));
                chk($sformatf("v%0d.eop", i), 512'(a_eop), 512'(tbl[i].fx[1]));
                chk($sformatf("v%0d.err", i), 512'(a_err), 512'(tbl[i].fx[0]));
                chk($sformatf("v%0d.mod", i), 512'(a_mod), 512'(tbl[i].mx));
                chk($sformatf("v%0d.ctl", i), 512'(a_ctl), 512'(tbl[i].tx));
                chk($sformatf("v%0d.dat", i), a_dat, x_dat);
            end
        end
        @(negedge clk);
        val0 = 1'b0; val1 = 1'b0;

        // ---- Asynchronous reset mid-packet with three words held (instance 0) ----
        ordy0 = 1'b0;
        for (int k = 0; k < 3; k++) begin
            val0 = 1'b1; sop0 = (k == 0); eop0 = 1'b0; err0 = 1'b0;
            mod0 = '0; ctl0 = 8'h50 + 8'(k); dat0 = {64{8'h50 + 8'(k)}};
            @(negedge clk);
        end
        val0 = 1'b0;
        #1;
        chk("pre.oval0", 512'(oval0), 512'(1));
        chk("pre.lvl0",  512'(lvl0),  512'(2));
        #1;
        rst0 = 1'b1;
        #1;
        chk("arst.oval0", 512'(oval0), 512'(0));
        chk("arst.osop0", 512'(osop0), 512'(0));
        chk("arst.octl0", 512'(octl0), 512'(0));
        chk("arst.odat0", odat0,       512'(0));
        chk("arst.lvl0",  512'(lvl0),  512'(0));
        chk("arst.irdy0", 512'(irdy0), 512'(0));
        @(negedge clk);
        rst0 = 1'b0;
        ordy0 = 1'b1;
        stale = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            if (oval0) stale++;
        end
        chk("post.stale_words", 512'(stale), 512'(0));
        chk("post.irdy0", 512'(irdy0), 512'(1));
        @(negedge clk);
        val0 = 1'b1; sop0 = 1'b1; eop0 = 1'b1; mod0 = 6'd7; ctl0 = 8'h77; dat0 = {64{8'h77}};
        @(negedge clk);
        val0 = 1'b0;
        @(negedge clk);
        #1;
        chk("post.oval0", 512'(oval0), 512'(1));
        chk("post.omod0", 512'(omod0), 512'(7));
        chk("post.odat0", odat0, {64{8'h77}});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
